// File: rtl/pkg_riscv.sv
// pkg_riscv: opcodes, FSM state encoding and datapath select encodings for the control unit
package pkg_riscv;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  typedef enum logic [2:0] {
    OCIOSO, BUSCA, DECODIFICA, EXECUTA, MEMORIA, ESCRITA, ERRO
  } estado_t;
  typedef enum logic [2:0] {
    IMM_I = 3'd0, IMM_S = 3'd1, IMM_J = 3'd2, IMM_U = 3'd3
  } sel_imm_t;
  typedef enum logic [1:0] {
    DIN_ULA = 2'd0, DIN_MEM = 2'd1, DIN_PC4 = 2'd2
  } sel_din_t;
  typedef enum logic [3:0] {
    C_ADD, C_SUB, C_ADDI, C_LD, C_SD, C_JAL, C_JALR, C_AUIPC, C_ILEGAL
  } classe_t;
  typedef struct packed {
    logic     legal;
    logic     subtraindo;
    logic     imediato;
    logic     sel_a;
    sel_imm_t sel_imm;
    sel_din_t sel_dinR;
    logic     escreve_reg;
    logic     memoria;
    logic     escreve_mem;
    logic     salto;
    logic     salto_reg;
  } ctrl_t;
endpackage

// File: rtl/decodificador.sv
// decodificador: maps opcode/funct fields to legality and per-class datapath selects
module decodificador
  import pkg_riscv::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output ctrl_t      ctrl
);
  classe_t classe;
  always_comb begin
    classe = opcode == OP_R && funct3 == 3'b000 && funct7 == 7'b0000000 ? C_ADD
      : opcode == OP_R && funct3 == 3'b000 && funct7 == 7'b0100000 ? C_SUB
      : opcode == OP_IMM && funct3 == 3'b000 ? C_ADDI
      : opcode == OP_LOAD && funct3 == 3'b011 ? C_LD
      : opcode == OP_STORE && funct3 == 3'b011 ? C_SD
      : opcode == OP_JAL ? C_JAL
      : opcode == OP_JALR && funct3 == 3'b000 ? C_JALR
      : opcode == OP_AUIPC ? C_AUIPC
      : C_ILEGAL;
    ctrl.legal       = classe != C_ILEGAL;
    ctrl.subtraindo  = classe == C_SUB;
    ctrl.imediato    = !(classe inside {C_ADD, C_SUB});
    ctrl.sel_a       = classe inside {C_JAL, C_AUIPC};
    ctrl.sel_imm     = classe == C_SD ? IMM_S : classe == C_JAL ? IMM_J : classe == C_AUIPC ? IMM_U : IMM_I;
    ctrl.sel_dinR    = classe == C_LD ? DIN_MEM : classe inside {C_JAL, C_JALR} ? DIN_PC4 : DIN_ULA;
    ctrl.escreve_reg = classe != C_ILEGAL && classe != C_SD;
    ctrl.memoria     = classe inside {C_LD, C_SD};
    ctrl.escreve_mem = classe == C_SD;
    ctrl.salto       = classe inside {C_JAL, C_JALR};
    ctrl.salto_reg   = classe == C_JALR;
  end
endmodule

// File: rtl/unidade_controle.sv
// unidade_controle: multicycle FSM sequencing the RV64 datapath; owns PC and instruction register
module unidade_controle
  import pkg_riscv::*;
#(
  parameter int          ENDR_W   = 7,
  parameter logic [63:0] PC_RESET = 64'h0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inicia,
  input  logic [31:0]       instr,
  input  logic [63:0]       doutULA,
  output logic [ENDR_W-1:0] endr,
  output logic [63:0]       pc,
  output logic [4:0]        Ra,
  output logic [4:0]        Rb,
  output logic [4:0]        Rw,
  output logic              WeR,
  output logic              WeM,
  output logic              soma_ou_subtrai,
  output logic              subtraindo,
  output logic              imediato,
  output logic              sel_a,
  output logic [2:0]        sel_imm,
  output logic [1:0]        sel_dinR,
  output logic              ocupado,
  output logic              erro
);
  estado_t     estado, prox;
  logic [31:0] ir;
  ctrl_t       c;
  logic        ativo, ula;
  decodificador u_dec (
    .opcode(ir[6:0]),
    .funct3(ir[14:12]),
    .funct7(ir[31:25]),
    .ctrl  (c)
  );
  assign endr = pc[ENDR_W+1:2];
  always_ff @(posedge clk) begin
    if (reset) begin
      estado <= OCIOSO;
      pc     <= PC_RESET;
      ir     <= '0;
    end else begin
      estado <= prox;
      if (estado == BUSCA) ir <= instr;
      if (estado == ESCRITA) pc <= c.salto ? (c.salto_reg ? {doutULA[63:1], 1'b0} : doutULA) : pc + 64'd4;
    end
  end
  always_comb begin
    prox = estado;
    unique case (estado)
      OCIOSO:     prox = inicia ? BUSCA : OCIOSO;
      BUSCA:      prox = DECODIFICA;
      DECODIFICA: prox = c.legal ? EXECUTA : ERRO;
      EXECUTA:    prox = c.memoria ? MEMORIA : ESCRITA;
      MEMORIA:    prox = ESCRITA;
      ESCRITA:    prox = BUSCA;
      default:    prox = ERRO;
    endcase
  end
  // ULA controls stay asserted through ESCRITA so doutULA remains valid for the PC/jump update
  always_comb begin
    ativo           = estado inside {DECODIFICA, EXECUTA, MEMORIA, ESCRITA};
    ula             = estado inside {EXECUTA, MEMORIA, ESCRITA};
    Ra              = ativo ? ir[19:15] : 5'd0;
    Rb              = ativo ? ir[24:20] : 5'd0;
    Rw              = ativo ? ir[11:7] : 5'd0;
    soma_ou_subtrai = ula;
    subtraindo      = ula && c.subtraindo;
    imediato        = ula && c.imediato;
    sel_a           = ula && c.sel_a;
    sel_imm         = ula ? c.sel_imm : IMM_I;
    WeM             = estado == MEMORIA && c.escreve_mem;
    WeR             = estado == ESCRITA && c.escreve_reg && ir[11:7] != 5'd0;
    sel_dinR        = estado == ESCRITA ? c.sel_dinR : DIN_ULA;
    ocupado         = ativo || estado == BUSCA;
    erro            = estado == ERRO;
  end
endmodule
